serial_add4: RTL

Bit-serial unsigned adder for the 4-bit ALU datapath. It is the addition counterpart of the ripple subtractor. It accepts two operands on a start pulse and resolves one bit per clock through a single full-adder cell. It returns a (WIDTH+1)-bit sum whose MSB is the carry-out, matching the subtractor's 5-bit result-with-borrow layout. It is used where area matters more than latency, and as a sequential reference for ALU add results.

---
 rtl/alu_pkg.sv | 12 +
 rtl/fadd.sv | 13 +
 rtl/serial_add4.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the small ALU datapath blocks.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/fadd.sv
// Single-bit combinational full adder.
module fadd (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add4.sv
// Bit-serial unsigned adder: one full-adder cell resolves one operand bit per clock.
// SUM[WIDTH] carries the carry-out, mirroring the subtractor's result-with-borrow layout.
module serial_add4
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   SUM
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] ps_shift;

  fadd u_fadd (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c    (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign ps_shift = {fa_sum, ps_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = 1'b0;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CntW'(1);
        ps_d  = ps_shift;
        if (cnt_q == LastCnt) begin
          sum_d   = {fa_cout, ps_shift};
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign SUM  = sum_q;

endmodule
